// File: rtl/corr_peak_detect_if.sv
// Sample stream into the correlation peak detector.
// The producer drives valid/data; the detector answers with ready.
interface corr_peak_detect_if #(
   parameter int DW = 16
);
   logic                 s_valid;
   logic signed [DW-1:0] s_data;
   logic                 s_ready;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );
endinterface

// File: rtl/corr_peak_detect.sv
// Scans one inverse-FFT correlation frame and reports the peak
// value, its row/col position and the signed motion vector.
module corr_peak_detect #(
   parameter int DW       = 16,
   parameter int LOG2_DIM = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   corr_peak_detect_if.slave      s,
   output logic                   busy,
   output logic                   done,
   output logic signed [DW-1:0]   peak_val,
   output logic [LOG2_DIM-1:0]    peak_row,
   output logic [LOG2_DIM-1:0]    peak_col,
   output logic signed [LOG2_DIM:0] mv_y,
   output logic signed [LOG2_DIM:0] mv_x
);
   localparam int KW = 2 * LOG2_DIM;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [KW-1:0]   r_k;
   logic            r_armed;
   logic            w_start;
   logic            w_acc;
   logic            w_last;
   logic            w_upd;
   logic            w_ready;

   // r_armed masks a start landing on the first edge after reset release
   assign w_start = start & r_armed;
   assign w_acc   = s.s_valid & w_ready;
   assign w_last  = (r_k == {KW{1'b1}});
   assign w_upd   = w_acc & ((r_k == '0) | (s.s_data > peak_val));

   assign s.s_ready = w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_next;
         r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start) w_next = SCAN;
         end
         SCAN: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            if (w_acc && w_last) w_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (w_start) w_next = SCAN;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k      <= '0;
         peak_val <= '0;
         peak_row <= '0;
         peak_col <= '0;
      end else begin
         if (w_start && r_state != SCAN) begin
            r_k <= '0;
         end else if (w_acc) begin
            r_k <= r_k + 1'b1;
         end
         if (w_upd) begin
            peak_val <= s.s_data;
            peak_row <= r_k[KW-1:LOG2_DIM];
            peak_col <= r_k[LOG2_DIM-1:0];
         end
      end
   end

   // Upper half of the index range is the negative shift
   assign mv_y = {peak_row[LOG2_DIM-1], peak_row};
   assign mv_x = {peak_col[LOG2_DIM-1], peak_col};
endmodule

// File: tb/tb_corr_peak_detect.sv
// Self-checking bench for corr_peak_detect: table vectors,
// randomized frames vs. a max/first-index model, reset corners.
module tb_corr_peak_detect;
   localparam int DW = 16;
   localparam int L  = 5;
   localparam int N  = 1024;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                busy;
   logic                done;
   logic signed [DW-1:0] peak_val;
   logic [L-1:0]        peak_row;
   logic [L-1:0]        peak_col;
   logic signed [L:0]   mv_y;
   logic signed [L:0]   mv_x;

   corr_peak_detect_if #(.DW(DW)) sif ();

   corr_peak_detect #(.DW(DW), .LOG2_DIM(L)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .s        (sif),
      .busy     (busy),
      .done     (done),
      .peak_val (peak_val),
      .peak_row (peak_row),
      .peak_col (peak_col),
      .mv_y     (mv_y),
      .mv_x     (mv_x)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic signed [DW-1:0] frame [N];

   typedef struct {
      int bg;
      int ka;
      int va;
      int kb;
      int vb;
      int ev;
      int er;
      int ec;
      int ey;
      int ex;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int mv(input int v);
      return (v < 16) ? v : v - 32;
   endfunction

   task automatic check_out(input string nm, input int ev, input int er,
                            input int ec, input int ey, input int ex);
      chk({nm, " done"}, int'(done), 1);
      chk({nm, " val"}, int'(peak_val), ev);
      chk({nm, " row"}, int'(peak_row), er);
      chk({nm, " col"}, int'(peak_col), ec);
      chk({nm, " mv_y"}, int'(mv_y), ey);
      chk({nm, " mv_x"}, int'(mv_x), ex);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, " s_ready"}, int'(sif.s_ready), 0);
      chk({nm, " busy"}, int'(busy), 0);
      chk({nm, " done"}, int'(done), 0);
      chk({nm, " val"}, int'(peak_val), 0);
      chk({nm, " row"}, int'(peak_row), 0);
      chk({nm, " col"}, int'(peak_col), 0);
      chk({nm, " mv_y"}, int'(mv_y), 0);
      chk({nm, " mv_x"}, int'(mv_x), 0);
   endtask

   task automatic fill(input int bg);
      for (int i = 0; i < N; i++) frame[i] = DW'(bg);
   endtask

   // Reference: largest value in the frame, earliest index holding it
   task automatic model(output int ev, output int er, output int ec,
                        output int ey, output int ex);
      int mx;
      int idx;
      mx = int'(frame[0]);
      for (int i = 1; i < N; i++)
         if (int'(frame[i]) > mx) mx = int'(frame[i]);
      idx = 0;
      while (int'(frame[idx]) != mx) idx++;
      ev = mx;
      er = idx / 32;
      ec = idx % 32;
      ey = mv(er);
      ex = mv(ec);
   endtask

   task automatic send_frame(input string nm, input int gap,
                             input bit mid_start, input int abort_at);
      int k;
      int cyc;
      bit hs;
      bit early;
      k = 0;
      cyc = 0;
      early = 0;
      @(negedge clk);
      start = 1'b1;
      sif.s_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk({nm, " busy"}, int'(busy), 1);
      while (k < N && cyc < 10000) begin
         if (abort_at >= 0 && k == abort_at) break;
         sif.s_valid = ($urandom_range(0, 99) >= gap);
         sif.s_data  = frame[k];
         start = mid_start && (k >= 300) && (k < 305);
         hs = sif.s_valid && sif.s_ready;
         if (done) early = 1;
         @(negedge clk);
         if (hs) k++;
         cyc++;
      end
      sif.s_valid = 1'b0;
      start = 1'b0;
      if (abort_at < 0) begin
         chk({nm, " accepted"}, k, N);
         chk({nm, " done_early"}, int'(early), 0);
         chk({nm, " done_lat"}, int'(done), 1);
         chk({nm, " busy_end"}, int'(busy), 0);
         chk({nm, " ready_end"}, int'(sif.s_ready), 0);
      end
   endtask

   initial begin
      int ev, er, ec, ey, ex;
      int t;

      tbl[0] = '{bg: 0,    ka: 70,   va: 1200, kb: -1,  vb: 0,
                 ev: 1200, er: 2,    ec: 6,    ey: 2,   ex: 6};
      tbl[1] = '{bg: 0,    ka: 1023, va: 900,  kb: -1,  vb: 0,
                 ev: 900,  er: 31,   ec: 31,   ey: -1,  ex: -1};
      tbl[2] = '{bg: -3,   ka: 10,   va: 500,  kb: 600, vb: 500,
                 ev: 500,  er: 0,    ec: 10,   ey: 0,   ex: 10};
      tbl[3] = '{bg: -100, ka: 528,  va: -5,   kb: -1,  vb: 0,
                 ev: -5,   er: 16,   ec: 16,   ey: -16, ex: -16};

      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");

      // start held across the release edge must not launch a scan
      start = 1'b1;
      @(posedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_at_release busy", int'(busy), 0);
      @(negedge clk);
      chk("start_at_release idle", int'(busy), 0);

      for (int i = 0; i < 4; i++) begin
         fill(tbl[i].bg);
         frame[tbl[i].ka] = DW'(tbl[i].va);
         if (tbl[i].kb >= 0) frame[tbl[i].kb] = DW'(tbl[i].vb);
         send_frame($sformatf("vec%0d", i), 0, 1'b0, -1);
         check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er,
                   tbl[i].ec, tbl[i].ey, tbl[i].ex);
      end

      // results hold in DONE and extra samples are refused
      repeat (6) begin
         sif.s_valid = 1'b1;
         sif.s_data  = 16'sd30000;
         chk("hold ready", int'(sif.s_ready), 0);
         @(negedge clk);
      end
      sif.s_valid = 1'b0;
      check_out("hold", tbl[3].ev, tbl[3].er, tbl[3].ec,
                tbl[3].ey, tbl[3].ex);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart done", int'(done), 0);
      chk("restart busy", int'(busy), 1);

      fill(tbl[0].bg);
      frame[tbl[0].ka] = DW'(tbl[0].va);
      send_frame("gappy", 50, 1'b1, -1);
      check_out("gappy", tbl[0].ev, tbl[0].er, tbl[0].ec,
                tbl[0].ey, tbl[0].ex);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r < 2) begin
               frame[i] = DW'($urandom);
            end else begin
               t = int'($urandom_range(0, 6)) - 3;
               frame[i] = DW'(t);
            end
         end
         model(ev, er, ec, ey, ex);
         send_frame($sformatf("rand%0d", r), r * 20, r[0], -1);
         check_out($sformatf("rand%0d", r), ev, er, ec, ey, ex);
      end

      fill(0);
      frame[100] = 16'sd5000;
      send_frame("abort", 0, 1'b0, 400);
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill(0);
      frame[33] = 16'sd77;
      send_frame("after_reset", 0, 1'b0, -1);
      check_out("after_reset", 77, 1, 1, 1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/corr_peak_detect.md
CORR_PEAK_DETECT -- requirements
Module: corr_peak_detect

Parameters
REQ-001 The block SHALL have parameter DW, default 16, meaning the signed sample width.
REQ-002 The block SHALL have parameter LOG2_DIM, default 5, meaning log2 of the matrix side (32x32 = 1024 samples).

Interface
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, width 1: begins a new frame scan.
REQ-006 The block SHALL have port s_valid, input, width 1: the sample on s_data is valid.
REQ-007 The block SHALL have port s_data, input, width DW, signed: real part of one inverse-FFT output sample.
REQ-008 The block SHALL have port s_ready, output, width 1: the block accepts a sample this cycle.
REQ-009 The block SHALL have port busy, output, width 1: high while in SCAN.
REQ-010 The block SHALL have port done, output, width 1: high while in DONE; results are valid.
REQ-011 The block SHALL have port peak_val, output, width DW, signed: the maximum sample value.
REQ-012 The block SHALL have ports peak_row and peak_col, output, width LOG2_DIM each: the peak position.
REQ-013 The block SHALL have ports mv_y and mv_x, output, width LOG2_DIM+1, signed: the motion vector.

Function
REQ-014 The block SHALL implement states IDLE, SCAN and DONE.
REQ-015 Transitions:
  - IDLE --start--> SCAN
  - SCAN --last sample accepted--> DONE
  - DONE --start--> SCAN
REQ-016 start SHALL be ignored in SCAN; the scan in progress is not disturbed.
REQ-017 s_ready SHALL equal (state==SCAN), with no combinational path from s_valid.
REQ-018 A sample SHALL be accepted only in a cycle where s_valid and s_ready are both high; s_valid low stalls the scan with no state change.
REQ-019 Sample index k SHALL run 0..1023 in acceptance order, with row = k[9:5] and col = k[4:0].
  - Index k corresponds to element bits [16k+15:16k] of the flattened inverse-FFT real output.
REQ-020 The first accepted sample (k=0) SHALL unconditionally load the running max, row 0 and col 0.
REQ-021 For k>0, the running max SHALL update only on a strict signed greater-than; on ties the lowest index wins.
REQ-022 Comparison SHALL be full-width signed with no saturation or scaling; negative-only frames SHALL yield the least-negative value.
REQ-023 Acceptance of k=1023 SHALL move the state to DONE on the same edge.
  - done, peak_* and mv_* become valid in the next cycle, i.e. 1 cycle after the last handshake.
  - Minimum frame time is 1025 cycles from start.
REQ-024 Motion vector arithmetic SHALL be mv_x = col when col<16, else col-32; mv_y is computed the same way from row.
  - Range is -16..+15; index 16 maps to -16.
REQ-025 peak_*, mv_*, peak_row and peak_col SHALL hold stable throughout DONE and change only after the next start.
REQ-026 A start in DONE SHALL drop done on the following cycle and reset the index counter to 0.
REQ-027 The index counter SHALL be LOG2_DIM*2 bits wide and wrap 1023->0 at the DONE transition; no sample SHALL be accepted after 1023.

Reset
REQ-028 While rst_n is low, the block SHALL asynchronously force:
  - state to IDLE and the index counter to 0;
  - s_ready, busy and done to 0;
  - peak_val, peak_row, peak_col, mv_x and mv_y to 0.
REQ-029 A reset asserted mid-SCAN SHALL abandon the partial frame with no result.
  - A fresh start after release SHALL scan from k=0.
REQ-030 A start coincident with the rst_n release edge SHALL be ignored.

Verification
REQ-031 The bench SHALL cover these scenarios:
  - All samples 0 except k=70 with value 1200 -> peak_val=1200, row=2, col=6, mv_y=2, mv_x=6, done 1 cycle after the last handshake.
  - Single peak 900 at k=1023 -> row=31, col=31, mv_y=-1, mv_x=-1.
  - Value 500 at k=10 and k=600 (tie), rest -3 -> k=10 wins: row=0, col=10, mv_x=10.
  - All samples -100 except -5 at k=528 -> peak_val=-5, row=16, col=16, mv_y=-16, mv_x=-16.
  - s_valid toggled randomly (about 50%), with start pulsed mid-SCAN -> same result as the gap-free run, and the scan is not restarted.
  - rst_n pulsed low at k=400, then a new frame with peak 77 at k=33 -> all outputs 0 during reset, then row=1, col=1, peak_val=77.
